// File: rtl/alu_bitscan_pkg.sv
// Shared op codes, FSM state encoding and small helpers for the bit-scan unit.
// Everything that must agree between the top level and its users lives here.
package alu_bitscan_pkg;

  localparam logic [2:0] BS_CLZ  = 3'b000;
  localparam logic [2:0] BS_CTZ  = 3'b001;
  localparam logic [2:0] BS_POPC = 3'b010;
  localparam logic [2:0] BS_PAR  = 3'b011;
  localparam logic [2:0] BS_FFS  = 3'b100;
  localparam logic [2:0] BS_BTST = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SCAN = 2'b01,
    S_DONE = 2'b10
  } bs_state_e;

  // CLZ is the only op that walks the operand from the most significant chunk down.
  function automatic logic scanFromMsb(input logic [2:0] opCode);
    return opCode == BS_CLZ;
  endfunction

  function automatic logic isDefinedOp(input logic [2:0] opCode);
    return opCode <= BS_BTST;
  endfunction

endpackage

// File: rtl/alu_chunk_count.sv
// Combinational per-chunk statistics: population count, leading and trailing
// zero counts, any-set and XOR of a CHUNK-bit slice.
module alu_chunk_count #(
  parameter int CHUNK = 4,
  parameter int KW    = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] chunk_i,
  output logic [KW-1:0]    popcnt_o,
  output logic [KW-1:0]    lz_o,
  output logic [KW-1:0]    tz_o,
  output logic             anySet_o,
  output logic             xor_o
);

  // An all-zero chunk reports CHUNK for both zero counts so the caller can
  // simply keep adding until the first set bit is seen.
  always_comb begin
    popcnt_o = '0;
    lz_o     = KW'(CHUNK);
    tz_o     = KW'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      popcnt_o = popcnt_o + KW'(chunk_i[i]);
      if (chunk_i[i]) begin
        lz_o = KW'(CHUNK - 1 - i);
      end
    end
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk_i[i]) begin
        tz_o = KW'(i);
      end
    end
  end

  assign anySet_o = |chunk_i;
  assign xor_o    = ^chunk_i;

endmodule

// File: rtl/alu_bitscan.sv
// Multi-cycle bit-query unit: CLZ/CTZ/POPC/PAR/FFS/BTST scanned CHUNK bits per
// cycle with a fixed latency of WIDTH/CHUNK scan cycles and valid/ready on both sides.
module alu_bitscan #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             invalid_op
);

  import alu_bitscan_pkg::*;

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = $clog2(WIDTH);
  localparam int AW = IW + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(CHUNK) + 1;

  bs_state_e        state_q,   state_d;
  logic [WIDTH-1:0] opA_q,     opA_d;
  logic [IW-1:0]    bitIdx_q,  bitIdx_d;
  logic [2:0]       opCode_q,  opCode_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [AW-1:0]    acc_q,     acc_d;
  logic             found_q,   found_d;
  logic             par_q,     par_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             zero_q,    zero_d;
  logic             carry_q,   carry_d;
  logic             invalid_q, invalid_d;

  logic [CW-1:0]    chunkSel;
  logic [CHUNK-1:0] chunkBits;
  logic [KW-1:0]    chunkPop;
  logic [KW-1:0]    chunkLz;
  logic [KW-1:0]    chunkTz;
  logic             chunkAny;
  logic             chunkXor;

  logic [AW-1:0]    stepAcc;
  logic             stepFound;
  logic             stepPar;
  logic             testedBit;
  logic [WIDTH-1:0] finResult;
  logic             finCarry;
  logic             finInvalid;
  logic             lastChunk;

  // Only the low index bits of b select the tested bit.
  logic unused_bHigh;
  assign unused_bHigh = ^b[WIDTH-1:IW];

  assign chunkSel  = scanFromMsb(opCode_q) ? (CW'(N - 1) - cnt_q) : cnt_q;
  assign chunkBits = opA_q[int'(chunkSel) * CHUNK +: CHUNK];
  assign lastChunk = (cnt_q == CW'(N - 1));
  assign testedBit = opA_q[bitIdx_q];

  alu_chunk_count #(
    .CHUNK(CHUNK),
    .KW   (KW)
  ) u_chunk (
    .chunk_i (chunkBits),
    .popcnt_o(chunkPop),
    .lz_o    (chunkLz),
    .tz_o    (chunkTz),
    .anySet_o(chunkAny),
    .xor_o   (chunkXor)
  );

  // Once found is set the zero counts freeze; FFS reuses the CTZ count.
  always_comb begin
    stepAcc   = acc_q;
    stepFound = found_q;
    stepPar   = par_q ^ chunkXor;
    case (opCode_q)
      BS_CLZ: begin
        if (!found_q) begin
          stepAcc   = acc_q + AW'(chunkLz);
          stepFound = chunkAny;
        end
      end
      BS_CTZ, BS_FFS: begin
        if (!found_q) begin
          stepAcc   = acc_q + AW'(chunkTz);
          stepFound = chunkAny;
        end
      end
      BS_POPC: stepAcc = acc_q + AW'(chunkPop);
      default: ;
    endcase
  end

  always_comb begin
    finResult  = '0;
    finCarry   = 1'b0;
    finInvalid = !isDefinedOp(opCode_q);
    case (opCode_q)
      BS_CLZ, BS_CTZ, BS_POPC: finResult = WIDTH'(stepAcc);
      BS_PAR:                  finResult = WIDTH'(stepPar);
      BS_FFS: begin
        if (stepFound) begin
          finResult = WIDTH'(stepAcc + AW'(1));
        end
      end
      BS_BTST: begin
        finResult = WIDTH'(testedBit);
        finCarry  = testedBit;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    opA_d     = opA_q;
    bitIdx_d  = bitIdx_q;
    opCode_d  = opCode_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    found_d   = found_q;
    par_d     = par_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    invalid_d = invalid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opA_d    = a;
          bitIdx_d = b[IW-1:0];
          opCode_d = op;
          cnt_d    = '0;
          acc_d    = '0;
          found_d  = 1'b0;
          par_d    = 1'b0;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        acc_d   = stepAcc;
        found_d = stepFound;
        par_d   = stepPar;
        cnt_d   = cnt_q + CW'(1);
        if (lastChunk) begin
          cnt_d     = '0;
          result_d  = finResult;
          zero_d    = (finResult == '0);
          carry_d   = finCarry;
          invalid_d = finInvalid;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opA_q     <= '0;
      bitIdx_q  <= '0;
      opCode_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      found_q   <= 1'b0;
      par_q     <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      bitIdx_q  <= bitIdx_d;
      opCode_q  <= opCode_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      found_q   <= found_d;
      par_q     <= par_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      invalid_q <= invalid_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign result     = result_q;
  assign zero       = zero_q;
  assign carry_out  = carry_q;
  assign invalid_op = invalid_q;

endmodule

// File: tb/tb_alu_bitscan.sv
// Scoreboard bench for alu_bitscan: requests push reference results into a
// queue; a monitor pops and compares whenever a result is handed over.
module tb_alu_bitscan;

  localparam int W = 32;
  localparam int N = 8;
  localparam logic [2:0] OP_CLZ  = 3'd0;
  localparam logic [2:0] OP_CTZ  = 3'd1;
  localparam logic [2:0] OP_POPC = 3'd2;
  localparam logic [2:0] OP_PAR  = 3'd3;
  localparam logic [2:0] OP_FFS  = 3'd4;
  localparam logic [2:0] OP_BTST = 3'd5;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        invalid;
    int          validEdge;
    string       tag;
  } exp_t;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [31:0] aIn;
  logic [31:0] bIn;
  logic [2:0]  opIn;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        zero;
  logic        carryOut;
  logic        invalidOp;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   lastAcceptEdge = 0;
  bit   randomReady = 0;
  bit   holdReady = 1;
  exp_t expQ[$];

  alu_bitscan #(.WIDTH(W), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (aIn),
    .b         (bIn),
    .op        (opIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .result    (result),
    .zero      (zero),
    .carry_out (carryOut),
    .invalid_op(invalidOp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready only ever changes just after a rising edge.
  initial begin
    outReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      outReady = randomReady ? ($urandom_range(0, 2) != 0) : holdReady;
    end
  end

  function automatic exp_t refModel(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    int   n;
    int   idx;
    e.result = '0; e.carry = 1'b0; e.invalid = 1'b0; e.validEdge = 0; e.tag = "";
    idx = int'(bv % 32);
    n = 0;
    case (o)
      OP_CLZ: begin
        while (n < W && !av[W-1-n]) n++;
        e.result = 32'(n);
      end
      OP_CTZ: begin
        while (n < W && !av[n]) n++;
        e.result = 32'(n);
      end
      OP_POPC: e.result = 32'($countones(av));
      OP_PAR:  e.result = {31'd0, ^av};
      OP_FFS: begin
        while (n < W && !av[n]) n++;
        e.result = (av == 0) ? 32'd0 : 32'(n + 1);
      end
      OP_BTST: begin
        e.result = {31'd0, av[idx]};
        e.carry  = av[idx];
      end
      default: e.invalid = 1'b1;
    endcase
    e.zero = (e.result == 0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic noteTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got timeout, expected a response within the cycle bound", name);
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input string tag);
    exp_t e;
    int   n = 0;
    e = refModel(o, av, bv);
    e.tag = tag;
    opIn = o; aIn = av; bIn = bv; inValid = 1'b1;
    while (!inReady && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) begin
      noteTimeout({tag, " accept"});
      inValid = 1'b0;
    end else begin
      lastAcceptEdge = cyc + 1;
      e.validEdge = lastAcceptEdge + N;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      aIn = $urandom;
      bIn = $urandom;
    end
  endtask

  task automatic waitDrained(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      noteTimeout({name, " drain"});
      expQ.delete();
    end
  endtask

  // Monitor: latency on the rising out_valid, stability while held, compare on handover.
  initial begin
    exp_t        e;
    bit          prevValid = 0;
    logic [31:0] heldResult = '0;
    logic [2:0]  heldFlags = '0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        prevValid = 0;
      end else if (outValid) begin
        if (!prevValid) begin
          checkOutput("scoreboard pending", 32'(expQ.size() != 0), 32'd1);
          if (expQ.size() != 0)
            checkOutput({expQ[0].tag, " latency"}, 32'(cyc), 32'(expQ[0].validEdge));
        end else begin
          checkOutput("held result", result, heldResult);
          checkOutput("held flags", {29'd0, zero, carryOut, invalidOp}, {29'd0, heldFlags});
        end
        checkOutput("in_ready in DONE", {31'd0, inReady}, 32'd0);
        heldResult = result;
        heldFlags  = {zero, carryOut, invalidOp};
        if (outReady && expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput({e.tag, " result"}, result, e.result);
          checkOutput({e.tag, " zero"}, {31'd0, zero}, {31'd0, e.zero});
          checkOutput({e.tag, " carry_out"}, {31'd0, carryOut}, {31'd0, e.carry});
          checkOutput({e.tag, " invalid_op"}, {31'd0, invalidOp}, {31'd0, e.invalid});
        end
        prevValid = 1;
      end else begin
        prevValid = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int releaseEdge;
    logic [31:0] av;
    rstN = 1'b0; inValid = 1'b0; aIn = '0; bIn = '0; opIn = '0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    checkOutput("reset out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("reset in_ready", {31'd0, inReady}, 32'd1);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset zero", {31'd0, zero}, 32'd0);
    checkOutput("reset carry_out", {31'd0, carryOut}, 32'd0);
    checkOutput("reset invalid_op", {31'd0, invalidOp}, 32'd0);

    $display("[TB] directed operations");
    applyStimulus(OP_CLZ,  32'h0001_0000, 32'd0, "CLZ 0x10000");
    applyStimulus(OP_CTZ,  32'h0001_0000, 32'd0, "CTZ 0x10000");
    applyStimulus(OP_CTZ,  32'h0000_0000, 32'd0, "CTZ zero");
    applyStimulus(OP_CLZ,  32'h0000_0000, 32'd0, "CLZ zero");
    applyStimulus(OP_FFS,  32'h0000_0000, 32'd0, "FFS zero");
    applyStimulus(OP_FFS,  32'h0000_0100, 32'd0, "FFS 0x100");
    applyStimulus(OP_POPC, 32'hF0F0_00FF, 32'd0, "POPC");
    applyStimulus(OP_PAR,  32'hF0F0_00FF, 32'd0, "PAR even");
    applyStimulus(OP_PAR,  32'h0000_0007, 32'd0, "PAR odd");
    applyStimulus(OP_BTST, 32'h8000_0000, 32'd31, "BTST b31");
    applyStimulus(OP_BTST, 32'h8000_0000, 32'hFFFF_FFFF, "BTST b all-ones");
    applyStimulus(OP_BTST, 32'h8000_0000, 32'd30, "BTST b30");
    applyStimulus(OP_CLZ,  32'h8000_0000, 32'd0, "CLZ msb");
    applyStimulus(OP_POPC, 32'hFFFF_FFFF, 32'd0, "POPC all");
    waitDrained("directed");

    $display("[TB] backpressure and back-to-back");
    holdReady = 1'b0;
    applyStimulus(OP_POPC, 32'h1234_5678, 32'd0, "POPC held");
    n = 0;
    while (!outValid && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!outValid) noteTimeout("backpressure out_valid");
    repeat (5) begin
      @(negedge clk);
      checkOutput("backpressure in_ready", {31'd0, inReady}, 32'd0);
      checkOutput("backpressure out_valid", {31'd0, outValid}, 32'd1);
    end
    @(posedge clk);
    holdReady = 1'b1;
    #2;
    releaseEdge = cyc + 1;
    applyStimulus(OP_FFS, 32'h0040_0000, 32'd0, "FFS back-to-back");
    checkOutput("back-to-back accept edge", 32'(lastAcceptEdge), 32'(releaseEdge + 1));
    waitDrained("backpressure");

    $display("[TB] reset during scan");
    opIn = OP_POPC; aIn = 32'hFFFF_0000; bIn = '0; inValid = 1'b1;
    n = 0;
    while (!inReady && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 inValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("scan in progress", {31'd0, inReady}, 32'd0);
    rstN = 1'b0;
    @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", {31'd0, inReady}, 32'd1);
    checkOutput("post-reset result", result, 32'd0);
    checkOutput("post-reset zero", {31'd0, zero}, 32'd0);
    checkOutput("post-reset carry_out", {31'd0, carryOut}, 32'd0);
    checkOutput("post-reset invalid_op", {31'd0, invalidOp}, 32'd0);
    repeat (N + 4) begin
      @(negedge clk);
      checkOutput("post-reset out_valid", {31'd0, outValid}, 32'd0);
    end
    applyStimulus(3'b111, 32'hDEAD_BEEF, 32'd3, "undefined 111");
    applyStimulus(3'b110, 32'h0000_0001, 32'd0, "undefined 110");
    waitDrained("undefined");

    $display("[TB] randomized operations");
    randomReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       av = 32'd0;
        1:       av = 32'd1 << $urandom_range(0, 31);
        2:       av = $urandom;
        default: av = $urandom & $urandom & $urandom;
      endcase
      applyStimulus(3'($urandom_range(0, 7)), av, $urandom, $sformatf("random %0d", i));
    end
    randomReady = 1'b0;
    waitDrained("random");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
